// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes FFT output samples at bit-reversed addresses
// and streams each completed frame out in natural order with valid/ready handshake.
module fft_bitrev_reorder #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_real,
    input  logic [W-1:0] i_imag,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_real,
    output logic [W-1:0] o_imag,
    output logic         o_first,
    output logic         o_last
);

    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Bank select is the MSB of the storage address.
    logic [2*W-1:0]   mem [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt_reg;
    logic [LOG2N-1:0] rd_cnt_reg;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_bank_reg;
    logic             rd_bank_reg;
    logic [1:0]       full_reg;
    logic [1:0]       full_next;
    logic             wr_en;
    logic             wr_wrap;
    logic             rd_load;
    logic             rd_wrap;

    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_cnt_reg[LOG2N-1-gi];
        end
    endgenerate

    assign o_in_ready = !full_reg[wr_bank_reg];
    assign wr_en      = i_valid && o_in_ready;
    assign wr_wrap    = wr_en && (wr_cnt_reg == LAST_IDX);
    assign rd_load    = full_reg[rd_bank_reg] && (!o_valid || i_ready);
    assign rd_wrap    = rd_load && (rd_cnt_reg == LAST_IDX);

    // Writer and reader always own different banks when both act, so set and clear never collide.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = (full_reg[gi] || (wr_wrap && (wr_bank_reg == 1'(gi))))
                                   && !(rd_wrap && (rd_bank_reg == 1'(gi)));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_addr}] <= {i_real, i_imag};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
        end else begin
            full_reg <= full_next;
            if (wr_en) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
                if (wr_wrap) begin
                    wr_bank_reg <= !wr_bank_reg;
                end
            end
            if (rd_load) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
                if (rd_wrap) begin
                    rd_bank_reg <= !rd_bank_reg;
                end
            end
        end
    end

    // Output register doubles as the registered RAM read port.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            o_real  <= '0;
            o_imag  <= '0;
        end else if (rd_load) begin
            {o_real, o_imag} <= mem[{rd_bank_reg, rd_cnt_reg}];
            o_valid          <= 1'b1;
            o_first          <= (rd_cnt_reg == '0);
            o_last           <= (rd_cnt_reg == LAST_IDX);
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: accepted samples are grouped into frames,
// permuted to natural order by a reference model, and compared by an independent monitor.
module tb_fft_bitrev_reorder;

    localparam int N     = 8;
    localparam int W     = 32;
    localparam int LOG2N = 3;

    logic         clk     = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [W-1:0] i_real  = '0;
    logic [W-1:0] i_imag  = '0;
    logic         o_in_ready;
    logic         o_valid;
    logic [W-1:0] o_real;
    logic [W-1:0] o_imag;
    logic         o_first;
    logic         o_last;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.N(N), .W(W)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .i_real     (i_real),
        .i_imag     (i_imag),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_real     (o_real),
        .o_imag     (o_imag),
        .o_first    (o_first),
        .o_last     (o_last)
    );

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         first;
        logic         last;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] in_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int send_stalls = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit stream_on = 1'b0;
    int stream_outs = 0;
    int stream_gaps = 0;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (v[b]) r |= (1 << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: frame sample arriving at position j belongs at natural index bitrev(j).
    always @(negedge clk) begin : input_model
        exp_t           e;
        logic [2*W-1:0] s;
        if (i_reset && i_valid && o_in_ready) begin
            acc_cnt++;
            in_q.push_back({i_real, i_imag});
            $display("in  #%0d re=%h im=%h", acc_cnt, i_real, i_imag);
            if (in_q.size() == N) begin
                for (int n = 0; n < N; n++) begin
                    s       = in_q[bitrev(n)];
                    e.re    = s[2*W-1:W];
                    e.im    = s[W-1:0];
                    e.first = (n == 0);
                    e.last  = (n == N - 1);
                    exp_q.push_back(e);
                end
                in_q.delete();
            end
        end
    end

    // Monitor: compares each handshake against the scoreboard and checks hold while stalled.
    logic         stall_prev = 1'b0;
    logic [W-1:0] hold_re, hold_im;
    logic         hold_first, hold_last;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!i_reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(o_valid), 64'(1));
                check("hold_real", 64'(o_real), 64'(hold_re));
                check("hold_imag", 64'(o_imag), 64'(hold_im));
                check("hold_flags", 64'({o_first, o_last}), 64'({hold_first, hold_last}));
            end
            if (o_valid && i_ready) begin
                out_cnt++;
                $display("out #%0d re=%h im=%h first=%0b last=%0b", out_cnt, o_real, o_imag, o_first, o_last);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got re=%h with empty scoreboard, required none", o_real);
                end else begin
                    e = exp_q.pop_front();
                    check("out_real", 64'(o_real), 64'(e.re));
                    check("out_imag", 64'(o_imag), 64'(e.im));
                    check("out_first", 64'(o_first), 64'(e.first));
                    check("out_last", 64'(o_last), 64'(e.last));
                end
            end
            if (stream_on) begin
                if (o_valid && i_ready) stream_outs++;
                else if (stream_outs > 0 && stream_outs < 4 * N) stream_gaps++;
            end
            stall_prev = o_valid && !i_ready;
            hold_re    = o_real;
            hold_im    = o_imag;
            hold_first = o_first;
            hold_last  = o_last;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [W-1:0] r, input logic [W-1:0] im);
        int t = 0;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_real  = r;
        i_imag  = im;
        @(negedge clk);
        while (!o_in_ready) begin
            t++;
            send_stalls++;
            if (t > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: o_in_ready stayed %0b, required 1", o_in_ready);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int acc0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_flags", 64'({o_first, o_last}), 64'(0));
        check("rst_real", 64'(o_real), 64'(0));
        check("rst_imag", 64'(o_imag), 64'(0));
        check("rst_in_ready", 64'(o_in_ready), 64'(1));
        i_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frame in bit-reversed order: 0,4,2,6,1,5,3,7
        for (int j = 0; j < N; j++) send(W'(bitrev(j)), W'(100 + bitrev(j)));
        idle();
        @(negedge clk);
        check("lat_before", 64'(o_valid), 64'(0));
        @(negedge clk);
        check("lat_valid", 64'(o_valid), 64'(1));
        check("lat_real", 64'(o_real), 64'(0));
        check("lat_imag", 64'(o_imag), 64'(100));
        check("lat_first", 64'(o_first), 64'(1));
        drain();

        // Four back-to-back frames
        send_stalls = 0;
        stream_outs = 0;
        stream_gaps = 0;
        stream_on   = 1'b1;
        for (int k = 0; k < 4 * N; k++) send($urandom, $urandom);
        idle();
        drain();
        stream_on = 1'b0;
        check("stream_in_stalls", 64'(send_stalls), 64'(0));
        check("stream_outs", 64'(stream_outs), 64'(4 * N));
        check("stream_gaps", 64'(stream_gaps), 64'(0));

        // Backpressure: two frames with downstream stalled
        ready_mode = 0;
        repeat (2) @(negedge clk);
        acc0 = acc_cnt;
        for (int k = 0; k < 2 * N; k++) send($urandom, $urandom);
        @(posedge clk); #1;
        i_real = 32'hDEAD_BEEF;
        i_imag = 32'hCAFE_F00D;
        @(negedge clk);
        check("bp_in_ready", 64'(o_in_ready), 64'(0));
        check("bp_valid", 64'(o_valid), 64'(1));
        check("bp_hold_idx0", 64'(o_real), 64'(exp_q[0].re));
        repeat (5) @(negedge clk);
        check("bp_no_accept", 64'(acc_cnt - acc0), 64'(2 * N));
        @(posedge clk); #1;
        i_valid    = 1'b0;
        ready_mode = 1;
        drain();

        // Random gaps and random downstream readiness over ten frames
        ready_mode = 2;
        for (int k = 0; k < 10 * N; k++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send($urandom, $urandom);
        end
        idle();
        drain();

        // Reset while frame 0 is reading out and frame 1 is partially written
        for (int k = 0; k < N + 5; k++) send($urandom, $urandom);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_reset = 1'b0;
        in_q.delete();
        exp_q.delete();
        #1;
        check("mrst_valid", 64'(o_valid), 64'(0));
        check("mrst_real", 64'(o_real), 64'(0));
        check("mrst_imag", 64'(o_imag), 64'(0));
        check("mrst_flags", 64'({o_first, o_last}), 64'(0));
        check("mrst_in_ready", 64'(o_in_ready), 64'(1));
        ready_mode = 1;
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        for (int k = 0; k < N; k++) send($urandom, $urandom);
        idle();
        drain();
        repeat (20) @(negedge clk);
        check("post_idle_valid", 64'(o_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
